// File: rtl/taiga_types.sv
// rtl/taiga_types.sv - shared types and helpers for the fetch-stage return-address-stack logic
package taiga_types;

  localparam int MAX_IDS = 4;

  typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POP_PUSH} ras_op_t;

  typedef enum logic [1:0] {RESET, RUN, RECOVER} ras_ctrl_state_t;

  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_interface.sv
// rtl/ras_interface.sv - command bundle between the RAS controller and the return-address stack
interface ras_interface;
  logic        push;
  logic        pop;
  logic [31:0] new_addr;
  logic        branch_fetched;
  logic        branch_retired;

  modport master (output push, pop, new_addr, branch_fetched, branch_retired);
  modport slave  (input  push, pop, new_addr, branch_fetched, branch_retired);
endinterface

// File: rtl/ras_op_decode.sv
// rtl/ras_op_decode.sv - combinational mapping of a control-transfer instruction to its RAS operation
module ras_op_decode
  import taiga_types::*;
(
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  output ras_op_t    op
);

  logic rd_link;
  logic rs1_link;

  assign rd_link  = is_link_reg(rd);
  assign rs1_link = is_link_reg(rs1);

  always_comb begin
    op = RAS_NONE;
    if (is_jal) begin
      if (rd_link) op = RAS_PUSH;
    end else if (is_jalr) begin
      unique case ({rd_link, rs1_link})
        2'b10:   op = RAS_PUSH;
        2'b01:   op = RAS_POP;
        // Same link register on both sides is a plain call (coroutine swap otherwise)
        2'b11:   op = (rd == rs1) ? RAS_PUSH : RAS_POP_PUSH;
        default: op = RAS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - sequences RAS push/pop commands from fetch and bounds in-flight speculative branches
module ras_ctrl
  import taiga_types::*;
#(
  parameter int MAX_OUTSTANDING = MAX_IDS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   gc_fetch_flush,
  input  logic                                   fetch_valid,
  input  logic                                   fetch_is_jal,
  input  logic                                   fetch_is_jalr,
  input  logic                                   fetch_is_branch,
  input  logic                                   fetch_is_compressed,
  input  logic [4:0]                             fetch_rd,
  input  logic [4:0]                             fetch_rs1,
  input  logic [31:0]                            fetch_pc,
  input  logic                                   branch_retired,
  output logic                                   fetch_stall,
  ras_interface.master                           ras,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ras_ctrl_state_t state, next_state;
  ras_op_t         op;
  logic            accepted;
  logic            speculative;
  logic            spec_accept;
  logic            count_full;
  logic            op_push;
  logic            op_pop;
  logic [31:0]     push_addr;

  ras_op_decode u_decode (
    .is_jal  (fetch_is_jal),
    .is_jalr (fetch_is_jalr),
    .rd      (fetch_rd),
    .rs1     (fetch_rs1),
    .op      (op)
  );

  assign speculative = fetch_is_branch | fetch_is_jalr;
  // A retire this cycle frees a checkpoint slot in time for a new branch
  assign count_full  = (outstanding == MAX_CNT) & ~branch_retired;
  assign spec_accept = accepted & speculative;
  assign op_push     = (op == RAS_PUSH) | (op == RAS_POP_PUSH);
  assign op_pop      = (op == RAS_POP)  | (op == RAS_POP_PUSH);
  assign push_addr   = fetch_pc + (fetch_is_compressed ? 32'd2 : 32'd4);

  always_ff @(posedge clk) begin
    if (rst) state <= RESET;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    fetch_stall = 1'b1;
    accepted    = 1'b0;
    unique case (state)
      RESET:   next_state = RUN;
      RUN: begin
        if (gc_fetch_flush) next_state = RECOVER;
        fetch_stall = count_full;
        accepted    = fetch_valid & ~count_full & ~gc_fetch_flush;
      end
      RECOVER: next_state = gc_fetch_flush ? RECOVER : RUN;
      default: next_state = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras.push           <= 1'b0;
      ras.pop            <= 1'b0;
      ras.new_addr       <= 32'd0;
      ras.branch_fetched <= 1'b0;
      ras.branch_retired <= 1'b0;
    end else begin
      ras.push           <= accepted & op_push;
      ras.pop            <= accepted & op_pop;
      ras.branch_fetched <= spec_accept;
      ras.branch_retired <= branch_retired & ~gc_fetch_flush;
      if (accepted && op_push) ras.new_addr <= push_addr;
    end
  end

  // Flush drops every checkpoint, so retires reported alongside it are moot
  always_ff @(posedge clk) begin
    if (rst || gc_fetch_flush) begin
      outstanding <= '0;
    end else if (spec_accept && !branch_retired) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!spec_accept && branch_retired && outstanding != '0) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  retire_underflow: assert property (@(posedge clk) disable iff (rst)
    (branch_retired && !gc_fetch_flush && !spec_accept) |-> (outstanding != '0));

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - self-checking bench for ras_ctrl against a behavioural RAS sequencing model
module tb_ras_ctrl;
  import taiga_types::*;

  localparam int MAXO = MAX_IDS;
  localparam int CW   = $clog2(MAXO + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, gc_fetch_flush, fetch_valid, fetch_is_jal, fetch_is_jalr, fetch_is_branch;
  logic          fetch_is_compressed, branch_retired, fetch_stall;
  logic [4:0]    fetch_rd, fetch_rs1;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;

  ras_interface ras_if ();

  ras_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .gc_fetch_flush      (gc_fetch_flush),
    .fetch_valid         (fetch_valid),
    .fetch_is_jal        (fetch_is_jal),
    .fetch_is_jalr       (fetch_is_jalr),
    .fetch_is_branch     (fetch_is_branch),
    .fetch_is_compressed (fetch_is_compressed),
    .fetch_rd            (fetch_rd),
    .fetch_rs1           (fetch_rs1),
    .fetch_pc            (fetch_pc),
    .branch_retired      (branch_retired),
    .fetch_stall         (fetch_stall),
    .ras                 (ras_if),
    .outstanding         (outstanding)
  );

  int checks = 0;
  int errors = 0;

  // Model: m_state 0 = first cycle out of reset, 1 = running, 2 = recovering after a flush
  int          m_state = 0;
  int          m_cnt   = 0;
  bit          e_push, e_pop, e_bf, e_ret, e_stall;
  logic [31:0] e_addr = 32'd0;
  logic        obs_stall;

  // 0 none, 1 push, 2 pop, 3 pop-then-push
  function automatic int ref_op(bit jal, bit jalr, logic [4:0] rd, logic [4:0] rs1);
    bit ld, ls;
    ld = (rd == 5'd1) || (rd == 5'd5);
    ls = (rs1 == 5'd1) || (rs1 == 5'd5);
    if (jal) return ld ? 1 : 0;
    if (!jalr) return 0;
    if (ld && !ls) return 1;
    if (!ld && ls) return 2;
    if (ld && ls) return (rd == rs1) ? 1 : 3;
    return 0;
  endfunction

  // Applies one cycle of inputs at a negedge, samples the stall, advances the model, returns at next negedge
  task automatic cyc(input bit r, input bit fl, input bit v, input bit jal, input bit jalr, input bit br,
                     input bit c, input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc,
                     input bit ret);
    bit acc, inc, dec;
    int op;
    rst = r; gc_fetch_flush = fl; fetch_valid = v; fetch_is_jal = jal; fetch_is_jalr = jalr;
    fetch_is_branch = br; fetch_is_compressed = c; fetch_rd = rd; fetch_rs1 = rs1; fetch_pc = pc;
    branch_retired = ret;
    #1 obs_stall = fetch_stall;
    e_stall = (m_state != 1) || (m_cnt == MAXO && !ret);
    acc = v && !e_stall && !fl && !r;
    op  = ref_op(jal, jalr, rd, rs1);
    if (r) begin
      e_push = 0; e_pop = 0; e_bf = 0; e_ret = 0; e_addr = 32'd0; m_cnt = 0; m_state = 0;
    end else begin
      e_push = acc && (op == 1 || op == 3);
      e_pop  = acc && (op == 2 || op == 3);
      e_bf   = acc && (br || jalr);
      e_ret  = ret && !fl;
      if (e_push) e_addr = pc + (c ? 32'd2 : 32'd4);
      inc = acc && (br || jalr);
      dec = ret && (m_cnt > 0 || inc);
      m_cnt = fl ? 0 : m_cnt + int'(inc) - int'(dec);
      m_state = (m_state == 0) ? 1 : (fl ? 2 : 1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ret);
    cyc(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, ret);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 0);
    checks++; if ({ras_if.push, ras_if.pop, ras_if.branch_fetched, ras_if.branch_retired} !== 4'b0) begin
      errors++; $display("FAIL reset_cmds got %b want 0000", {ras_if.push, ras_if.pop, ras_if.branch_fetched, ras_if.branch_retired}); end
    checks++; if (ras_if.new_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", ras_if.new_addr); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    idle(0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_first got %b want 1", obs_stall); end
    idle(0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_run got %b want 0", obs_stall); end
  endtask

  task automatic test_jal_push();
    cyc(0, 0, 1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h1000, 0);
    checks++; if (ras_if.push !== 1'b1 || ras_if.pop !== 1'b0) begin
      errors++; $display("FAIL jal_push got push=%b pop=%b want 1 0", ras_if.push, ras_if.pop); end
    checks++; if (ras_if.new_addr !== 32'h1004) begin errors++; $display("FAIL jal_addr got %h want 00001004", ras_if.new_addr); end
    checks++; if (ras_if.branch_fetched !== 1'b0) begin errors++; $display("FAIL jal_bf got %b want 0", ras_if.branch_fetched); end
    idle(0);
    checks++; if (ras_if.push !== 1'b0) begin errors++; $display("FAIL jal_one_cycle got %b want 0", ras_if.push); end
  endtask

  task automatic test_compressed_pop();
    cyc(0, 0, 1, 0, 1, 0, 1, 5'd0, 5'd5, 32'h2002, 0);
    checks++; if ({ras_if.pop, ras_if.push, ras_if.branch_fetched} !== 3'b101) begin
      errors++; $display("FAIL cpop_cmds got %b want 101", {ras_if.pop, ras_if.push, ras_if.branch_fetched}); end
    checks++; if (outstanding !== CW'(1)) begin errors++; $display("FAIL cpop_outstanding got %0d want 1", outstanding); end
  endtask

  task automatic test_pop_push_wrap();
    cyc(0, 0, 1, 0, 1, 0, 0, 5'd1, 5'd5, 32'hFFFF_FFFC, 0);
    checks++; if ({ras_if.push, ras_if.pop} !== 2'b11) begin errors++; $display("FAIL poppush_cmds got %b want 11", {ras_if.push, ras_if.pop}); end
    checks++; if (ras_if.new_addr !== 32'h0) begin errors++; $display("FAIL poppush_wrap got %h want 00000000", ras_if.new_addr); end
    cyc(0, 0, 1, 0, 1, 0, 0, 5'd1, 5'd1, 32'h3000, 0);
    checks++; if ({ras_if.push, ras_if.pop} !== 2'b10) begin errors++; $display("FAIL same_link_cmds got %b want 10", {ras_if.push, ras_if.pop}); end
    checks++; if (ras_if.new_addr !== 32'h3004) begin errors++; $display("FAIL same_link_addr got %h want 00003004", ras_if.new_addr); end
    for (int i = 0; i < 3; i++) idle(1);
    checks++; if (ras_if.branch_retired !== 1'b1) begin errors++; $display("FAIL retire_pass got %b want 1", ras_if.branch_retired); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL retire_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < MAXO; i++) cyc(0, 0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 32'h100 + 32'(4 * i), 0);
    checks++; if (outstanding !== CW'(MAXO)) begin errors++; $display("FAIL fill_count got %0d want %0d", outstanding, MAXO); end
    cyc(0, 0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 32'h200, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL fill_stall got %b want 1", obs_stall); end
    checks++; if (ras_if.branch_fetched !== 1'b0) begin errors++; $display("FAIL fill_blocked got %b want 0", ras_if.branch_fetched); end
    cyc(0, 0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 32'h204, 1);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL fill_retire_stall got %b want 0", obs_stall); end
    checks++; if (ras_if.branch_fetched !== 1'b1) begin errors++; $display("FAIL fill_retire_bf got %b want 1", ras_if.branch_fetched); end
    checks++; if (outstanding !== CW'(MAXO)) begin errors++; $display("FAIL fill_retire_count got %0d want %0d", outstanding, MAXO); end
  endtask

  task automatic test_flush();
    cyc(0, 1, 1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h4000, 1);
    checks++; if ({ras_if.push, ras_if.branch_retired} !== 2'b00) begin
      errors++; $display("FAIL flush_kill got %b want 00", {ras_if.push, ras_if.branch_retired}); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", outstanding); end
    cyc(0, 0, 1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h4004, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL flush_recover got %b want 1", obs_stall); end
    checks++; if (ras_if.push !== 1'b0) begin errors++; $display("FAIL flush_recover_cmd got %b want 0", ras_if.push); end
    idle(0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_run got %b want 0", obs_stall); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 1, 1, 0, 0, 0, 5'd5, 5'd0, 32'h5000, 0);
    checks++; if (ras_if.push !== 1'b1) begin errors++; $display("FAIL mid_pre_push got %b want 1", ras_if.push); end
    cyc(1, 0, 1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h5004, 0);
    checks++; if ({ras_if.push, ras_if.pop, ras_if.branch_fetched, ras_if.branch_retired} !== 4'b0 || ras_if.new_addr !== 32'd0) begin
      errors++; $display("FAIL mid_reset_outputs got cmds=%b addr=%h want 0000 0", {ras_if.push, ras_if.pop, ras_if.branch_fetched, ras_if.branch_retired}, ras_if.new_addr); end
    idle(0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL mid_stall_first got %b want 1", obs_stall); end
    idle(0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL mid_stall_run got %b want 0", obs_stall); end
  endtask

  task automatic test_random();
    bit r, fl, v, c, ret;
    int cls;
    logic [4:0] rd, rs1;
    logic [31:0] pc;
    logic [4:0] picks [4];
    for (int i = 0; i < 400; i++) begin
      picks[0] = 5'd0; picks[1] = 5'd1; picks[2] = 5'd5; picks[3] = 5'($urandom_range(31, 0));
      r   = ($urandom_range(99, 0) == 0);
      fl  = ($urandom_range(19, 0) == 0);
      v   = ($urandom_range(3, 0) != 0);
      c   = $urandom_range(1, 0) == 1;
      cls = $urandom_range(3, 0);
      rd  = picks[$urandom_range(3, 0)];
      rs1 = picks[$urandom_range(3, 0)];
      pc  = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFE - 32'(2 * $urandom_range(2, 0)) : {$urandom} & 32'hFFFF_FFFE;
      ret = (m_cnt > 0) && ($urandom_range(2, 0) == 0);
      cyc(r, fl, v, cls == 1, cls == 2, cls == 3, c, rd, rs1, pc, ret);
      checks++; if (obs_stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %b want %b", i, obs_stall, e_stall); end
      checks++; if ({ras_if.push, ras_if.pop} !== {e_push, e_pop}) begin
        errors++; $display("FAIL rnd_pushpop[%0d] got %b want %b", i, {ras_if.push, ras_if.pop}, {e_push, e_pop}); end
      checks++; if (ras_if.new_addr !== e_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, ras_if.new_addr, e_addr); end
      checks++; if ({ras_if.branch_fetched, ras_if.branch_retired} !== {e_bf, e_ret}) begin
        errors++; $display("FAIL rnd_bf_ret[%0d] got %b want %b", i, {ras_if.branch_fetched, ras_if.branch_retired}, {e_bf, e_ret}); end
      checks++; if (outstanding !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, outstanding, m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; gc_fetch_flush = 1'b0; fetch_valid = 1'b0; fetch_is_jal = 1'b0; fetch_is_jalr = 1'b0;
    fetch_is_branch = 1'b0; fetch_is_compressed = 1'b0; fetch_rd = 5'd0; fetch_rs1 = 5'd0;
    fetch_pc = 32'd0; branch_retired = 1'b0;
    @(negedge clk);
    test_reset();
    test_jal_push();
    test_compressed_pop();
    test_pop_push_wrap();
    test_fill();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address-stack sequencing controller for the fetch stage. It decodes each fetched control-transfer instruction into the RAS operations (push, pop, pop-then-push) and registers them into `ras_interface` commands. It also tracks speculative branches in flight so the RAS checkpoint FIFO (depth `MAX_IDS`) never overflows, and enforces a recovery bubble after `gc_fetch_flush`. It sits between fetch/decode and `ras`; each core instantiates one.

## Interface
- `MAX_OUTSTANDING`, default `MAX_IDS`: speculative branches allowed in flight; must equal the RAS checkpoint FIFO depth.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `gc_fetch_flush  in  1`: misprediction/global flush.
- `fetch_valid  in  1`: fetch-stage instruction valid this cycle.
- `fetch_is_jal`, `fetch_is_jalr`, `fetch_is_branch  in  1 each`: instruction class; at most one is set.
- `fetch_is_compressed  in  1`: 16-bit instruction.
- `fetch_rd`, `fetch_rs1  in  5 each`: register fields.
- `fetch_pc  in  32`: instruction PC.
- `branch_retired  in  1`: one speculative branch resolved and retired.
- `fetch_stall  out  1`: fetch must hold; the instruction is not accepted.
- `ras  ras_interface.master`: drives `push`, `pop`, `new_addr`, `branch_fetched`, `branch_retired`.
- `outstanding  out  $clog2(MAX_OUTSTANDING+1)`: in-flight speculative branch count.

## Operation
- Link register: rd or rs1 ∈ {x1, x5}.
- Decode:
  - JAL with link rd → PUSH.
  - JALR, rd link and rs1 non-link → PUSH.
  - JALR, rd non-link and rs1 link → POP.
  - JALR, both link and rd≠rs1 → POP_PUSH.
  - JALR, both link and rd==rs1 → PUSH.
  - Anything else → NONE.
- Speculative = `fetch_is_branch | fetch_is_jalr`.
- Accepted = `fetch_valid & ~fetch_stall & state==RUN & ~gc_fetch_flush`.
- Push address = `fetch_pc + (fetch_is_compressed ? 2 : 4)`, 32-bit modulo arithmetic; wraps at 0xFFFFFFFF.
- State machine:
  - RESET → RUN after the first cycle out of reset.
  - RUN → RECOVER on `gc_fetch_flush`.
  - RECOVER → RUN after exactly one cycle.
  - RECOVER persists while `gc_fetch_flush` stays asserted.
- In RECOVER all `ras` commands are 0 and `fetch_stall`=1.
- Outstanding counter:
  - +1 on an accepted speculative instruction.
  - −1 on `branch_retired`.
  - Both in the same cycle → unchanged.
  - Cleared to 0 on `gc_fetch_flush` (retire in the same cycle is ignored).
  - Retire at 0 is a protocol error: counter saturates at 0 and an assertion fires.
- `fetch_stall` = (state≠RUN) | (outstanding==MAX_OUTSTANDING & ~branch_retired).
  - Only speculative instructions are actually blocked by the count condition; non-speculative instructions still stall, so a simple fetch stage can use one stall signal.

## Timing
- Commands are registered: an instruction accepted in cycle N drives `ras.push`/`pop`/`new_addr`/`branch_fetched` in cycle N+1, for exactly one cycle.
- POP_PUSH asserts `push` and `pop` in the same cycle. RAS net index is unchanged and the top entry is overwritten.
- `ras.branch_retired` is `branch_retired` registered by one cycle.
- A flush in cycle N:
  - Kills the command registered in N; nothing issues in N+1.
  - `ras.branch_retired` is forced 0 in N+1.
- `outstanding` is a registered value. `fetch_stall` is combinational from state, `outstanding` and `branch_retired`.
- Reset values: all `ras` outputs 0, `new_addr` 0, `outstanding` 0, state RESET, `fetch_stall` 1.
- Reset mid-operation discards any registered command the following cycle.

## Structure
- Shared package `taiga_types` holds:
  - `typedef enum logic[1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POP_PUSH} ras_op_t`.
  - Function `is_link_reg(logic[4:0])`.
  - `ras_ctrl_state_t` {RESET, RUN, RECOVER}.
- Sub-module `ras_op_decode`: purely combinational; takes instruction class and fields, returns `ras_op_t`. It is reused by the branch predictor checker.

## Test plan
- JAL rd=x1 at PC 0x1000, not compressed → cycle+1: `push`=1, `new_addr`=0x1004, `branch_fetched`=0.
- Compressed JALR rd=x0 rs1=x5 at 0x2002 → `pop`=1, `push`=0, `branch_fetched`=1; `outstanding` goes 0→1.
- JALR rd=x1 rs1=x5 at 0xFFFFFFFC → `push`=`pop`=1, `new_addr`=0x00000000. Same case with rd=rs1=x1 → push only.
- Fill the counter: `MAX_OUTSTANDING` branches with no retire → `fetch_stall`=1. Retire in the same cycle as the next branch → accepted; count stays at max.
- `gc_fetch_flush` in the same cycle as an accepted JAL and a retire → no command next cycle, `outstanding`=0, stall for one RECOVER cycle, then RUN.
- `rst` pulsed while a PUSH is registered → no push issued; all outputs at reset values; `fetch_stall`=1 for one cycle.
